// File: rtl/screen_scanner_pkg.sv
// Shared timing constants, stage types and address helper for the monochrome
// screen scanner.
package screen_scanner_pkg;

  localparam int DEF_H_ACTIVE = 512;
  localparam int DEF_H_TOTAL  = 640;
  localparam int DEF_V_ACTIVE = 256;
  localparam int DEF_V_TOTAL  = 288;
  localparam int DEF_HS_START = 528;
  localparam int DEF_HS_LEN   = 64;
  localparam int DEF_VS_START = 264;
  localparam int DEF_VS_LEN   = 4;

  localparam int WORDS_PER_ROW = 32;
  localparam int PIPE_LAT      = 3;
  localparam int ADDR_W        = 13;
  localparam int WORD_W        = 16;

  typedef struct packed {
    logic hs;
    logic vs;
    logic fs;
  } sync_t;

  // Screen word holding pixel (col, row); 16 pixels per word, LSB leftmost.
  function automatic logic [ADDR_W-1:0] word_addr(input int unsigned row,
                                                  input int unsigned col);
    int unsigned a;
    a = row * WORDS_PER_ROW + col / WORD_W;
    return a[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/screen_scanner_pixel_shifter.sv
// 16-bit load/shift-right register; a load wins over a shift in the same cycle.
module pixel_shifter
  import screen_scanner_pkg::*;
#(
  parameter int DATA_W = WORD_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              lsb
);

  logic [DATA_W-1:0] sreg;

  always_ff @(posedge clock) begin
    if (reset)      sreg <= '0;
    else if (load)  sreg <= din;
    else if (shift) sreg <= sreg >> 1;
  end

  assign lsb = sreg[0];

endmodule

// File: rtl/screen_scanner.sv
// Raster scanner: walks the frame, fetches screen words one cycle ahead and
// serialises them into a 3-cycle aligned pixel/sync output pipeline.
module screen_scanner
  import screen_scanner_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_LEN   = DEF_HS_LEN,
  parameter int VS_START = DEF_VS_START,
  parameter int VS_LEN   = DEF_VS_LEN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] scr_addr,
  input  logic [WORD_W-1:0] scr_data,
  output logic              pixel,
  output logic              pixel_valid,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start,
  output logic [15:0]       frame_count
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  logic [HW-1:0] h, h_nxt;
  logic [VW-1:0] v, v_nxt;
  logic          h_last, v_last;
  logic          act_c, ld_c, nxt_ld;
  sync_t         sync_c;

  logic          vld_p0, ld_p0;
  sync_t         sync_p0;
  logic          vld_p1;
  sync_t         sync_p1;
  logic          lsb_p1;

  assign h_last = (h == HW'(H_TOTAL - 1));
  assign v_last = (v == VW'(V_TOTAL - 1));

  // Next scan position; a held scan parks at (0, 0) so a restart begins there.
  always_comb begin
    h_nxt = '0;
    v_nxt = '0;
    if (enable) begin
      h_nxt = h_last ? '0 : h + HW'(1);
      v_nxt = v;
      if (h_last) v_nxt = v_last ? '0 : v + VW'(1);
    end
  end

  always_comb begin
    act_c     = enable && (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
    ld_c      = act_c && (h[3:0] == 4'd0);
    sync_c.hs = enable && (32'(h) >= HS_START) && (32'(h) < HS_START + HS_LEN);
    sync_c.vs = enable && (32'(v) >= VS_START) && (32'(v) < VS_START + VS_LEN);
    sync_c.fs = enable && (h == '0) && (v == '0);
    nxt_ld    = (32'(h_nxt) < H_ACTIVE) && (32'(v_nxt) < V_ACTIVE) &&
                (h_nxt[3:0] == 4'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h           <= '0;
      v           <= '0;
      frame_count <= '0;
    end else begin
      h <= h_nxt;
      v <= v_nxt;
      if (enable && h_last && v_last) frame_count <= frame_count + 16'd1;
    end
  end

  // Address runs one position ahead of the counters so the word is back from
  // memory by the time the word's first column reaches the load stage.
  always_ff @(posedge clock) begin
    if (reset)       scr_addr <= '0;
    else if (nxt_ld) scr_addr <= word_addr(32'(v_nxt), 32'(h_nxt));
  end

  // ---- stage p0: position flags registered; scr_data for ld_p0 arrives now
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      ld_p0   <= 1'b0;
      sync_p0 <= '0;
    end else begin
      vld_p0  <= act_c;
      ld_p0   <= ld_c;
      sync_p0 <= sync_c;
    end
  end

  // ---- stage p1: word loaded into / shifted through the serialiser
  pixel_shifter #(
    .DATA_W(WORD_W)
  ) u_shifter (
    .clock(clock),
    .reset(reset),
    .load (ld_p0),
    .shift(vld_p0),
    .din  (scr_data),
    .lsb  (lsb_p1)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      sync_p1 <= '0;
    end else begin
      vld_p1  <= vld_p0;
      sync_p1 <= sync_p0;
    end
  end

  // ---- stage p2: registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      pixel       <= 1'b0;
      pixel_valid <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel       <= vld_p1 & lsb_p1;
      pixel_valid <= vld_p1;
      hsync       <= sync_p1.hs;
      vsync       <= sync_p1.vs;
      frame_start <= sync_p1.fs;
    end
  end

endmodule

// File: tb/tb_screen_scanner.sv
// Directed bench for screen_scanner on a reduced raster (80x10 total, 64x6
// active) so several whole frames fit in a short run.
module tb_screen_scanner;

  localparam int HA   = 64;
  localparam int HT   = 80;
  localparam int VA   = 6;
  localparam int VT   = 10;
  localparam int HSS  = 68;
  localparam int HSL  = 6;
  localparam int VSS  = 7;
  localparam int VSL  = 2;
  localparam int FR   = HT * VT;
  localparam int NREC = 3 * FR;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        pixel, pixel_valid, hsync, vsync, frame_start;
  logic [15:0] frame_count;

  logic [15:0] mem [0:8191];
  logic [12:0] mem_a;

  logic [4:0]  rec      [0:NREC-1];
  logic [12:0] rec_addr [0:NREC-1];
  logic [15:0] rec_fc   [0:NREC-1];

  int n_checks = 0;
  int n_fail   = 0;

  screen_scanner #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
    .HS_START(HSS), .HS_LEN(HSL), .VS_START(VSS), .VS_LEN(VSL)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .scr_addr   (scr_addr),
    .scr_data   (scr_data),
    .pixel      (pixel),
    .pixel_valid(pixel_valid),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_start(frame_start),
    .frame_count(frame_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Synchronous memory: data for the address held in a cycle appears just
  // after the following rising edge.
  initial begin
    scr_data = '0;
    forever begin
      @(negedge clock);
      mem_a = scr_addr;
      @(posedge clock);
      #1;
      scr_data = mem[mem_a];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic record(input int n);
    for (int k = 0; k < n; k++) begin
      tick(1);
      rec[k]      = {frame_start, vsync, hsync, pixel_valid, pixel};
      rec_addr[k] = scr_addr;
      rec_fc[k]   = frame_count;
    end
  endtask

  function automatic int cnt(input int b, input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (rec[k][b]) c++;
    return c;
  endfunction

  function automatic int addr_off(input int lo, input int hi, input logic [12:0] a);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (rec_addr[k] !== a) c++;
    return c;
  endfunction

  initial begin
    int base;
    logic [12:0] amax;

    reset  = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    mem[0]  = 16'h0001;
    mem[33] = 16'h8000;

    @(negedge clock);
    tick(2);
    enable = 1'b1;
    tick(1);
    check("reset_outs", {pixel, pixel_valid, hsync, vsync, frame_start}, 0);
    check("reset_addr", scr_addr, 0);
    check("reset_fc", frame_count, 0);

    // Sample k is taken after the (k+1)-th enabled edge; position p shows at sample p+2.
    reset = 1'b0;
    record(NREC);

    check("fs_before", rec[1][4], 0);
    check("fs_first", rec[2][4], 1);
    check("fs_frame1", rec[FR+2][4], 1);
    check("fs_count", cnt(4, 0, NREC-1), 3);
    check("pix_0_0", rec[2][0], 1);
    check("pix_1_0", rec[3][0], 0);
    check("pix_31_1", rec[2+HT+31][0], 1);
    check("pix_frame0", cnt(0, 0, FR-1), 2);
    check("pix_total", cnt(0, 0, NREC-1), 6);
    check("pv_edges_l0", {rec[1][1], rec[2][1], rec[65][1], rec[66][1]}, 4'b0110);

    for (int l = 0; l < VT; l++) begin
      base = FR + l * HT + 2;
      check($sformatf("pv_line%0d", l), cnt(1, base, base+HT-1), (l < VA) ? HA : 0);
      check($sformatf("hs_line%0d", l), cnt(2, base, base+HT-1), HSL);
      check($sformatf("hs_edge%0d", l), {rec[base+HSS-1][2], rec[base+HSS][2]}, 2'b01);
    end
    check("vs_count", cnt(3, FR, 2*FR-1), VSL * HT);
    check("vs_edge", {rec[FR+2+VSS*HT-1][3], rec[FR+2+VSS*HT][3]}, 2'b01);

    amax = '0;
    for (int k = 0; k < NREC; k++) if (rec_addr[k] > amax) amax = rec_addr[k];
    check("addr_max", amax, 163);
    check("addr_hblank", addr_off(47, 78, 13'd3), 0);
    check("addr_line1", rec_addr[79], 32);
    check("addr_vblank", addr_off(447, 798, 13'd163), 0);
    check("addr_wrap", rec_addr[FR-1], 0);

    check("fc_pre_wrap", rec_fc[FR-2], 0);
    check("fc_post_wrap", rec_fc[FR-1], 1);
    check("fc_3frames", frame_count, 3);

    // Counter wrap from all-ones.
    force dut.frame_count = 16'hFFFF;
    #1;
    release dut.frame_count;
    tick(1);
    check("fc_preload", frame_count, 16'hFFFF);
    tick(FR-2);
    check("fc_hold_ffff", frame_count, 16'hFFFF);
    tick(1);
    check("fc_wrap0", frame_count, 0);

    // Hold mid-frame at (30,3); the pixel at (29,3) is still in flight.
    mem[97] = 16'h2000;
    tick(3*HT + 30);
    enable = 1'b0;
    tick(2);
    check("dis_inflight", {pixel, pixel_valid}, 2'b11);
    tick(1);
    check("dis_flush", {pixel, pixel_valid, hsync, vsync, frame_start}, 0);
    tick(7);
    check("dis_hold", {pixel, pixel_valid, hsync, vsync, frame_start}, 0);
    check("dis_addr", scr_addr, 0);
    check("dis_fc", frame_count, 0);
    enable = 1'b1;
    tick(2);
    check("reen_fs_early", frame_start, 0);
    tick(1);
    check("reen_fs", frame_start, 1);
    check("reen_pix", pixel, 1);
    tick(FR-4);
    check("reen_fc_hold", frame_count, 0);
    tick(1);
    check("reen_fc_inc", frame_count, 1);

    // Reset for one cycle at (20,2).
    tick(2*HT + 20);
    check("pre_rst_addr", scr_addr, 65);
    check("pre_rst_pv", pixel_valid, 1);
    reset = 1'b1;
    tick(1);
    check("rst_outs", {pixel, pixel_valid, hsync, vsync, frame_start}, 0);
    check("rst_addr", scr_addr, 0);
    check("rst_fc", frame_count, 0);
    reset = 1'b0;
    tick(2);
    check("rst_fs_early", frame_start, 0);
    tick(1);
    check("rst_fs", frame_start, 1);
    check("rst_pix", pixel, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
